gesture_pulse_tx: RTL and testbench

// Transmit side of the three-line gesture link feeding the RGB LED indicator.

---
 rtl/gesture_pulse_tx.sv | 175 +++++++++++++++++
 tb/tb_gesture_pulse_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_pulse_tx.sv
// Gesture link transmitter: debounces three active-low keys and sends framed active-low pulses.
// Optional build macro GESTURE_LOCK_EN: accept only one gesture frame per reset.
module gesture_pulse_tx #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned PULSE_CYC    = 50_000,
  parameter int unsigned GAP_CYC      = 50_000,
  parameter int unsigned ROCK_PULSES  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_scissors,
  input  logic key_paper,
  input  logic key_rock,
  output logic tx_data_1,
  output logic tx_data_2,
  output logic tx_data_3,
  output logic busy,
  output logic frame_done
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned PC_W = $clog2(PULSE_CYC + 1);
  localparam int unsigned GC_W = $clog2(GAP_CYC + 1);
  localparam int unsigned PL_W = $clog2(ROCK_PULSES + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PC_W-1:0] P_LAST    = PC_W'(PULSE_CYC - 1);
  localparam logic [GC_W-1:0] G_LAST    = GC_W'(GAP_CYC - 1);
  localparam logic [PL_W-1:0] ROCK_LEFT = PL_W'(ROCK_PULSES);
  localparam logic [PL_W-1:0] ONE_LEFT  = PL_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_GAP, S_DONE} state_t;

  // Bit order everywhere: [0] scissors / tx_data_1, [1] paper / tx_data_2, [2] rock / tx_data_3
  logic [2:0]      keys;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q, db_d, db_prev_q;
  logic [DB_W-1:0] dbc_q [3];
  logic [DB_W-1:0] dbc_d [3];
  logic [2:0]      ev, ev_acc;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [PL_W-1:0] left_q, left_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [GC_W-1:0] gcnt_q, gcnt_d;
  logic [2:0]      tx_q, tx_d;
  logic            busy_q, fd_q;

  assign keys = {key_rock, key_paper, key_scissors};

  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    for (int unsigned i = 0; i < 3; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                     dbc_d[i] = dbc_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      for (int unsigned i = 0; i < 3; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q   <= keys;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int unsigned i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  assign ev = db_prev_q & ~db_q;

`ifdef GESTURE_LOCK_EN
  logic lock_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                lock_q <= 1'b0;
    else if (state_q == S_DONE) lock_q <= 1'b1;
  end
  assign ev_acc = lock_q ? '0 : ev;
`else
  assign ev_acc = ev;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    left_d  = left_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: begin
        if (ev_acc != '0) begin
          state_d = S_LOW;
          pcnt_d  = '0;
          if (ev_acc[1]) begin
            sel_d  = 3'b010;
            left_d = ONE_LEFT;
          end else if (ev_acc[0]) begin
            sel_d  = 3'b001;
            left_d = ONE_LEFT;
          end else begin
            sel_d  = 3'b100;
            left_d = ROCK_LEFT;
          end
        end
      end
      S_LOW: begin
        if (pcnt_q == P_LAST) begin
          state_d = S_GAP;
          pcnt_d  = '0;
          gcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PC_W'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == G_LAST) begin
          gcnt_d = '0;
          left_d = left_q - ONE_LEFT;
          if (left_d != '0) begin
            state_d = S_LOW;
            pcnt_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          gcnt_d = gcnt_q + GC_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are derived from the next state so the registered lines align with the state register
    tx_d = '1;
    if (state_d == S_LOW) tx_d = ~sel_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      left_q  <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      tx_q    <= '1;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      left_q  <= left_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
      fd_q    <= (state_d == S_DONE);
    end
  end

  assign tx_data_1  = tx_q[0];
  assign tx_data_2  = tx_q[1];
  assign tx_data_3  = tx_q[2];
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_gesture_pulse_tx.sv
// Directed bench for gesture_pulse_tx: reset, paper/rock/scissors frames, debounce, priority, abort.
// Build with GESTURE_LOCK_EN defined to exercise the one-gesture-per-round lock.
module tb_gesture_pulse_tx;

  localparam int DEB   = 4;
  localparam int PULSE = 3;
  localparam int GAP   = 2;
  localparam int ROCK  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_scissors = 1'b1;
  logic key_paper = 1'b1;
  logic key_rock = 1'b1;
  logic tx_data_1, tx_data_2, tx_data_3, busy, frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  int pulses[3], bad_w[3], bad_gap[3], last_low[3], first_low[3];
  int busy_cnt, fd_cnt, fd_idx;
  logic [2:0] end_lines;

  gesture_pulse_tx #(
    .DEBOUNCE_CYC(DEB),
    .PULSE_CYC(PULSE),
    .GAP_CYC(GAP),
    .ROCK_PULSES(ROCK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_scissors(key_scissors),
    .key_paper(key_paper),
    .key_rock(key_rock),
    .tx_data_1(tx_data_1),
    .tx_data_2(tx_data_2),
    .tx_data_3(tx_data_3),
    .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    key_scissors = 1'b1;
    key_paper    = 1'b1;
    key_rock     = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Samples every negedge for ncyc cycles and gathers per-line pulse statistics
  task automatic observe(input int ncyc);
    logic [2:0] prev, cur;
    int run[3];
    prev = 3'b111;
    busy_cnt = 0;
    fd_cnt = 0;
    fd_idx = -1;
    for (int i = 0; i < 3; i++) begin
      pulses[i] = 0; bad_w[i] = 0; bad_gap[i] = 0;
      last_low[i] = -1; first_low[i] = -1; run[i] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cur = {tx_data_3, tx_data_2, tx_data_1};
      for (int i = 0; i < 3; i++) begin
        if (prev[i] && !cur[i]) begin
          if (pulses[i] > 0 && run[i] != GAP) bad_gap[i]++;
          if (first_low[i] < 0) first_low[i] = c;
          pulses[i]++;
          run[i] = 0;
        end else if (!prev[i] && cur[i]) begin
          if (run[i] != PULSE) bad_w[i]++;
          last_low[i] = c - 1;
          run[i] = 0;
        end
        run[i]++;
      end
      if (busy) busy_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_idx = c;
      end
      prev = cur;
    end
    end_lines = prev;
  endtask

  initial begin
    int waited;
    int lat;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_tx1", int'(tx_data_1), 1);
    chk("rst_tx2", int'(tx_data_2), 1);
    chk("rst_tx3", int'(tx_data_3), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: paper held 10 cycles -> one 3-cycle pulse on line 2
    fork
      begin
        key_paper = 1'b0;
        repeat (10) @(negedge clk);
        key_paper = 1'b1;
      end
      observe(30);
    join
    chk("paper_pulses", pulses[1], 1);
    chk("paper_width", bad_w[1], 0);
    chk("paper_tx1_quiet", pulses[0], 0);
    chk("paper_tx3_quiet", pulses[2], 0);
    chk("paper_fd_cnt", fd_cnt, 1);
    chk("paper_fd_pos", fd_idx - last_low[1], GAP + 1);
    chk("paper_busy", busy_cnt, PULSE + GAP + 1);
    chk("paper_idle_lines", int'(end_lines), 7);

    // 3: rock -> three pulses, 15-cycle frame, then frame_done
    do_reset();
    fork
      key_rock = 1'b0;
      observe(40);
    join
    chk("rock_pulses", pulses[2], ROCK);
    chk("rock_width", bad_w[2], 0);
    chk("rock_gap", bad_gap[2], 0);
    chk("rock_frame_len", fd_idx - first_low[2], ROCK * (PULSE + GAP));
    chk("rock_fd_cnt", fd_cnt, 1);
    chk("rock_busy", busy_cnt, ROCK * (PULSE + GAP) + 1);
    chk("rock_other_quiet", pulses[0] + pulses[1], 0);

    // 4: scissors bounce 0-1 then steady low -> single pulse after a full stable window
    do_reset();
    fork
      begin
        key_scissors = 1'b0;
        @(negedge clk);
        key_scissors = 1'b1;
        @(negedge clk);
        key_scissors = 1'b0;
      end
      observe(40);
    join
    lat = first_low[0] - 2;
    chk("sc_latency_ok", int'(lat >= DEB + 2 && lat <= DEB + 4), 1);
    chk("sc_pulses", pulses[0], 1);
    chk("sc_width", bad_w[0], 0);
    chk("sc_fd_cnt", fd_cnt, 1);

    // 5: paper and rock together -> paper wins; scissors during busy is dropped
    do_reset();
    fork
      begin
        key_paper = 1'b0;
        key_rock  = 1'b0;
        repeat (2) @(negedge clk);
        key_scissors = 1'b0;
      end
      observe(40);
    join
    chk("prio_paper", pulses[1], 1);
    chk("prio_rock_drop", pulses[2], 0);
    chk("busy_sc_drop", pulses[0], 0);
    chk("prio_fd_cnt", fd_cnt, 1);

    // 6: reset in the middle of a rock frame
    do_reset();
    key_rock = 1'b0;
    waited = 0;
    while (tx_data_3 !== 1'b0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_start_seen", int'(tx_data_3), 0);
    repeat (PULSE + GAP) @(negedge clk);
    chk("abort_pre_low", int'(tx_data_3), 0);
    rst_n = 1'b0;
    key_rock = 1'b1;
    @(negedge clk);
    chk("abort_tx3", int'(tx_data_3), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_fd", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    observe(20);
    chk("abort_no_fd", fd_cnt, 0);
    chk("abort_no_pulse", pulses[0] + pulses[1] + pulses[2], 0);

    // 7: a second gesture after a completed frame
    do_reset();
    fork
      begin
        key_paper = 1'b0;
        repeat (10) @(negedge clk);
        key_paper = 1'b1;
      end
      observe(30);
    join
    chk("round1_paper", pulses[1], 1);
    fork
      key_rock = 1'b0;
      observe(40);
    join
`ifdef GESTURE_LOCK_EN
    chk("round2_rock", pulses[2], 0);
    chk("round2_busy", busy_cnt, 0);
    chk("round2_fd", fd_cnt, 0);
`else
    chk("round2_rock", pulses[2], ROCK);
    chk("round2_busy", busy_cnt, ROCK * (PULSE + GAP) + 1);
    chk("round2_fd", fd_cnt, 1);
`endif
    key_rock = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
